// File: rtl/vx_fetch_stage.sv
// Instruction fetch stage: issues one icache read per scheduled warp,
// parks warp metadata per warp id and merges it with the cache response.
module vx_fetch_stage #(
    parameter  int NUM_WARPS   = 4,
    parameter  int NUM_THREADS = 4,
    parameter  int XLEN        = 32,
    parameter  int UUID_WIDTH  = 44,
    parameter  int MAX_PENDING = 4,
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sched_valid,
    output logic                   sched_ready,
    input  logic [NW_WIDTH-1:0]    sched_wid,
    input  logic [NUM_THREADS-1:0] sched_tmask,
    input  logic [XLEN-1:0]        sched_pc,
    input  logic [UUID_WIDTH-1:0]  sched_uuid,
    output logic                   icache_req_valid,
    input  logic                   icache_req_ready,
    output logic [XLEN-3:0]        icache_req_addr,
    output logic [NW_WIDTH-1:0]    icache_req_tag,
    input  logic                   icache_rsp_valid,
    output logic                   icache_rsp_ready,
    input  logic [NW_WIDTH-1:0]    icache_rsp_tag,
    input  logic [31:0]            icache_rsp_data,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [NW_WIDTH-1:0]    fetch_wid,
    output logic [NUM_THREADS-1:0] fetch_tmask,
    output logic [XLEN-1:0]        fetch_pc,
    output logic [UUID_WIDTH-1:0]  fetch_uuid,
    output logic [31:0]            fetch_instr,
    output logic [NUM_WARPS-1:0]   pending_warps,
    output logic                   err_unexpected_rsp,
    output logic                   busy
);

    typedef struct packed {
        logic [NW_WIDTH-1:0]    wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [XLEN-1:0]        pc;
        logic [UUID_WIDTH-1:0]  uuid;
        logic [31:0]            instr;
    } fetch_t;

    localparam logic [CNT_W-1:0] CREDITS = CNT_W'(MAX_PENDING);

    logic [NUM_WARPS-1:0]   pending;
    logic [NUM_WARPS-1:0]   pend_nxt;
    logic [CNT_W-1:0]       pend_cnt;
    logic [NUM_THREADS-1:0] tab_tmask [NUM_WARPS];
    logic [XLEN-1:0]        tab_pc    [NUM_WARPS];
    logic [UUID_WIDTH-1:0]  tab_uuid  [NUM_WARPS];
    fetch_t                 obuf      [2];
    fetch_t                 push_ent;
    fetch_t                 head;
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             ocnt;
    logic                   err_q;

    logic can_issue;
    logic req_fire;
    logic rsp_fire;
    logic rsp_hit;
    logic pop;

    // Outputs are gated by reset so nothing handshakes while it is held.
    assign can_issue        = ~pending[sched_wid] & (pend_cnt < CREDITS);
    assign icache_req_valid = reset & sched_valid & can_issue;
    assign sched_ready      = reset & icache_req_ready & can_issue;
    assign icache_req_addr  = sched_pc[XLEN-1:2];
    assign icache_req_tag   = sched_wid;
    assign req_fire         = sched_valid & sched_ready;

    assign icache_rsp_ready = reset & (ocnt != 2'd2);
    assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;
    assign rsp_hit          = rsp_fire & pending[icache_rsp_tag];

    assign fetch_valid = (ocnt != 2'd0);
    assign pop         = fetch_valid & fetch_ready;

    assign push_ent = '{wid:   icache_rsp_tag,
                        tmask: tab_tmask[icache_rsp_tag],
                        pc:    tab_pc[icache_rsp_tag],
                        uuid:  tab_uuid[icache_rsp_tag],
                        instr: icache_rsp_data};

    always_comb begin
        pend_nxt = pending;
        if (rsp_hit)
            pend_nxt[icache_rsp_tag] = 1'b0;
        if (req_fire)
            pend_nxt[sched_wid] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            pend_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (req_fire & ~rsp_hit)
                pend_cnt <= pend_cnt + 1'b1;
            else if (rsp_hit & ~req_fire)
                pend_cnt <= pend_cnt - 1'b1;
            if (rsp_fire & ~pending[icache_rsp_tag])
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                tab_tmask[i] <= '0;
                tab_pc[i]    <= '0;
                tab_uuid[i]  <= '0;
            end
        end else if (req_fire) begin
            tab_tmask[sched_wid] <= sched_tmask;
            tab_pc[sched_wid]    <= sched_pc;
            tab_uuid[sched_wid]  <= sched_uuid;
        end
    end

    // Two-entry ring; a full buffer refuses responses even when popping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obuf[0] <= '0;
            obuf[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            ocnt    <= 2'd0;
        end else begin
            if (rsp_hit) begin
                obuf[wr_ptr] <= push_ent;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (rsp_hit & ~pop)
                ocnt <= ocnt + 2'd1;
            else if (pop & ~rsp_hit)
                ocnt <= ocnt - 2'd1;
        end
    end

    assign head               = obuf[rd_ptr];
    assign fetch_wid          = head.wid;
    assign fetch_tmask        = head.tmask;
    assign fetch_pc           = head.pc;
    assign fetch_uuid         = head.uuid;
    assign fetch_instr        = head.instr;
    assign pending_warps      = pending;
    assign err_unexpected_rsp = err_q;
    assign busy               = (|pending) | fetch_valid;

endmodule
